angle_output_sequencer: RTL and testbench

- Controller ahead of the combined SPI/register-map output unit.
- Once the register map reports configured, it snapshots one roll/pitch/yaw sample from the filter. It then drives write_enable/output_select to ship roll, pitch and yaw in order over SPI.
- For each axis it waits for the output unit's done before moving on, and guards every word with a timeout.

---
 rtl/angle_output_sequencer.sv | 139 +++++++++++++
 tb/tb_angle_output_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/angle_output_sequencer.sv
// Sequences one roll/pitch/yaw snapshot into the SPI output unit, one word per
// load strobe, waiting for each word's done with a per-word timeout.
module angle_output_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4,
  parameter int CNT_W          = 13
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        configured_in,
  input  logic        sample_valid_in,
  input  logic [15:0] roll_in,
  input  logic [15:0] pitch_in,
  input  logic [15:0] yaw_in,
  input  logic        done_in,
  output logic [15:0] roll_out,
  output logic [15:0] pitch_out,
  output logic [15:0] yaw_out,
  output logic        write_enable_out,
  output logic [1:0]  output_select_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        timeout_out,
  output logic        overrun_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_LOAD, S_WAIT_DONE, S_GAP, S_FRAME_END
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       SEL_NONE = 2'b11;

  state_t           state;
  logic [1:0]       axis;
  logic [CNT_W-1:0] timer;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= S_IDLE;
      axis              <= 2'd0;
      timer             <= '0;
      roll_out          <= 16'h0000;
      pitch_out         <= 16'h0000;
      yaw_out           <= 16'h0000;
      write_enable_out  <= 1'b0;
      output_select_out <= SEL_NONE;
      busy_out          <= 1'b0;
      frame_done_out    <= 1'b0;
      timeout_out       <= 1'b0;
      overrun_out       <= 1'b0;
    end else begin
      write_enable_out <= 1'b0;
      frame_done_out   <= 1'b0;
      timeout_out      <= 1'b0;
      overrun_out      <= 1'b0;
      if (!configured_in) begin
        // Abort wins over everything; snapshots are deliberately kept.
        state             <= S_IDLE;
        axis              <= 2'd0;
        timer             <= '0;
        output_select_out <= SEL_NONE;
        busy_out          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_ARMED;
          S_ARMED: begin
            if (sample_valid_in) begin
              roll_out          <= roll_in;
              pitch_out         <= pitch_in;
              yaw_out           <= yaw_in;
              axis              <= 2'd0;
              timer             <= '0;
              write_enable_out  <= 1'b1;
              output_select_out <= 2'd0;
              busy_out          <= 1'b1;
              state             <= S_LOAD;
            end
          end
          S_LOAD: begin
            // Timer runs from the strobe cycle, so the abort lands
            // TIMEOUT_CYCLES clocks after the load strobe.
            overrun_out <= sample_valid_in;
            timer       <= timer + CNT_ONE;
            state       <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            overrun_out <= sample_valid_in;
            if (done_in) begin
              timer <= '0;
              if (axis == 2'd2) begin
                frame_done_out    <= 1'b1;
                output_select_out <= SEL_NONE;
                busy_out          <= 1'b0;
                state             <= S_FRAME_END;
              end else begin
                state <= S_GAP;
              end
            end else if (timer == TO_LAST) begin
              timeout_out       <= 1'b1;
              output_select_out <= SEL_NONE;
              busy_out          <= 1'b0;
              axis              <= 2'd0;
              timer             <= '0;
              state             <= S_ARMED;
            end else begin
              timer <= timer + CNT_ONE;
            end
          end
          S_GAP: begin
            overrun_out <= sample_valid_in;
            if (timer == GAP_LAST) begin
              timer             <= '0;
              axis              <= axis + 2'd1;
              write_enable_out  <= 1'b1;
              output_select_out <= axis + 2'd1;
              state             <= S_LOAD;
            end else begin
              timer <= timer + CNT_ONE;
            end
          end
          S_FRAME_END: begin
            overrun_out <= sample_valid_in;
            axis        <= 2'd0;
            state       <= S_ARMED;
          end
          default: begin
            state             <= S_IDLE;
            output_select_out <= SEL_NONE;
            busy_out          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_angle_output_sequencer.sv
// Random + directed bench for angle_output_sequencer; a cycle-count model
// predicts every output and a compare process checks it each cycle.
module tb_angle_output_sequencer;
  localparam int TO  = 16;
  localparam int GAP = 4;

  logic clk, n_rst, cfg, sv, done;
  logic [15:0] roll, pitch, yaw;
  logic [15:0] roll_o, pitch_o, yaw_o;
  logic we, busy, fd, to_p, ov;
  logic [1:0] sel;

  angle_output_sequencer #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .CNT_W(13)) dut (
    .clk(clk), .n_rst(n_rst), .configured_in(cfg), .sample_valid_in(sv),
    .roll_in(roll), .pitch_in(pitch), .yaw_in(yaw), .done_in(done),
    .roll_out(roll_o), .pitch_out(pitch_o), .yaw_out(yaw_o),
    .write_enable_out(we), .output_select_out(sel), .busy_out(busy),
    .frame_done_out(fd), .timeout_out(to_p), .overrun_out(ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame progress tracked as cycles since the last strobe and gap
  // cycles remaining; expected outputs describe the cycle after each edge.
  bit m_armed, m_frame, m_fend;
  int m_axis, m_since, m_gap;
  logic [15:0] e_roll, e_pitch, e_yaw;
  logic e_we, e_busy, e_fd, e_to, e_ov;
  logic [1:0] e_sel;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_armed = 0; m_frame = 0; m_fend = 0; m_axis = 0; m_since = 0; m_gap = 0;
      e_roll = 0; e_pitch = 0; e_yaw = 0;
      e_we = 0; e_busy = 0; e_fd = 0; e_to = 0; e_ov = 0; e_sel = 2'b11;
    end else begin
      e_we = 0; e_fd = 0; e_to = 0; e_ov = 0;
      if (!cfg) begin
        m_armed = 0; m_frame = 0; m_fend = 0; e_sel = 2'b11; e_busy = 0;
      end else if (!m_armed) begin
        m_armed = 1;
      end else if (m_fend) begin
        m_fend = 0; e_ov = sv;
      end else if (!m_frame) begin
        if (sv) begin
          e_roll = roll; e_pitch = pitch; e_yaw = yaw;
          m_frame = 1; m_axis = 0; m_since = 0; m_gap = 0;
          e_we = 1; e_sel = 2'd0; e_busy = 1;
        end
      end else begin
        e_ov = sv;
        if (m_gap > 0) begin
          m_gap--;
          if (m_gap == 0) begin
            m_axis++; m_since = 0; e_we = 1; e_sel = 2'(m_axis);
          end
        end else if (m_since >= 1 && done) begin
          if (m_axis == 2) begin
            m_frame = 0; m_fend = 1; e_fd = 1; e_sel = 2'b11; e_busy = 0;
          end else m_gap = GAP;
        end else if (m_since == TO - 1) begin
          m_frame = 0; e_to = 1; e_sel = 2'b11; e_busy = 0;
        end else m_since++;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_roll", roll_o, e_roll);
    chk("cmp_pitch", pitch_o, e_pitch);
    chk("cmp_yaw", yaw_o, e_yaw);
    chk("cmp_we", we, e_we);
    chk("cmp_sel", sel, e_sel);
    chk("cmp_busy", busy, e_busy);
    chk("cmp_fd", fd, e_fd);
    chk("cmp_to", to_p, e_to);
    chk("cmp_ov", ov, e_ov);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int nwe;

  initial begin
    n_rst = 0; cfg = 0; sv = 0; done = 0; roll = 0; pitch = 0; yaw = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", sel, 2'b11); chk("rst_busy", busy, 0);
    chk("rst_we", we, 0); chk("rst_roll", roll_o, 0);
    n_rst = 1; tick();

    // Unconfigured: sample ignored
    roll = 16'h0F0F; pitch = 16'hA5A5; yaw = 16'h5E0D; sv = 1; tick(); sv = 0;
    tick();
    chk("uncfg_we", we, 0); chk("uncfg_ov", ov, 0); chk("uncfg_roll", roll_o, 0);

    cfg = 1; tick(); tick();
    sv = 1; tick(); sv = 0; roll = 16'hFFFF;
    chk("f1_we", we, 1); chk("f1_sel0", sel, 0); chk("f1_busy", busy, 1);
    chk("f1_roll", roll_o, 16'h0F0F); chk("f1_pitch", pitch_o, 16'hA5A5);
    chk("f1_yaw", yaw_o, 16'h5E0D);
    repeat (3) tick();
    done = 1; tick(); done = 0;
    repeat (GAP - 1) tick();
    chk("f1_gap_we", we, 0);
    tick();
    chk("f1_we_p", we, 1); chk("f1_sel1", sel, 1);
    // Overrun during pitch wait
    tick(); tick();
    roll = 16'h1234; sv = 1; tick(); sv = 0;
    chk("ovr_pulse", ov, 1); chk("ovr_roll", roll_o, 16'h0F0F); chk("ovr_busy", busy, 1);
    tick();
    done = 1; tick(); done = 0;
    repeat (GAP) tick();
    chk("f1_we_y", we, 1); chk("f1_sel2", sel, 2);
    tick(); tick();
    done = 1; tick(); done = 0;
    chk("f1_fd", fd, 1); chk("f1_sel_end", sel, 2'b11); chk("f1_busy_end", busy, 0);
    tick();
    chk("f1_fd_once", fd, 0);

    // Timeout: no done after roll strobe
    roll = 16'h00AA; sv = 1; tick(); sv = 0;
    chk("to_we", we, 1);
    repeat (TO - 1) tick();
    chk("to_early", to_p, 0);
    tick();
    chk("to_pulse", to_p, 1); chk("to_sel", sel, 2'b11);
    chk("to_busy", busy, 0); chk("to_fd", fd, 0);
    sv = 1; tick(); sv = 0;
    chk("to_restart_we", we, 1); chk("to_restart_sel", sel, 0);

    // done on the terminal count wins
    repeat (TO - 1) tick();
    done = 1; tick(); done = 0;
    chk("term_to", to_p, 0); chk("term_busy", busy, 1);
    repeat (GAP) tick();
    chk("term_we", we, 1); chk("term_sel", sel, 1);

    // Drop configured during the gap after pitch
    tick(); tick();
    done = 1; tick(); done = 0;
    tick();
    cfg = 0; tick();
    chk("drop_sel", sel, 2'b11); chk("drop_busy", busy, 0);
    cfg = 1; nwe = 0;
    repeat (10) begin tick(); if (we) nwe++; end
    chk("drop_nostrobe", nwe, 0);

    // Asynchronous reset mid-frame
    sv = 1; tick(); sv = 0; tick(); tick();
    #2 n_rst = 0;
    #1;
    chk("arst_sel", sel, 2'b11); chk("arst_busy", busy, 0); chk("arst_roll", roll_o, 0);
    @(posedge clk); #1 n_rst = 1;

    // Randomized traffic
    repeat (3000) begin
      if (cfg) cfg = ($urandom_range(0, 199) != 0);
      else     cfg = ($urandom_range(0, 3) == 0);
      sv    = ($urandom_range(0, 7) == 0);
      done  = ($urandom_range(0, 5) == 0);
      roll  = 16'($urandom); pitch = 16'($urandom); yaw = 16'($urandom);
      tick();
    end
    sv = 0; done = 0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
